// File: rtl/record_sequencer.sv
// record_sequencer: pops fifo records, drops NOPs, halts on STOP, forwards the rest over valid/ready.
module record_sequencer #(
    parameter int WordSize    = 8,
    parameter int RecordWords = 16,
    parameter int CountWidth  = 16,
    localparam int RecW       = WordSize * RecordWords
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_clear,
    input  logic                  i_fifo_empty,
    input  logic [RecW-1:0]       i_fifo_data,
    output logic                  o_fifo_read_en,
    output logic                  o_seg_valid,
    input  logic                  i_seg_ready,
    output logic [RecW-1:0]       o_seg_data,
    output logic                  o_halted,
    output logic                  o_underrun,
    output logic [CountWidth-1:0] o_records_out,
    output logic [CountWidth-1:0] o_underrun_count
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t                r_state, w_next;
    logic                  r_seg_valid, r_halted, r_underrun, r_primed, r_starve_d;
    logic [RecW-1:0]       r_seg_data;
    logic [CountWidth-1:0] r_records_out, r_underrun_count;
    logic [7:0]            w_op;
    logic                  w_pop, w_fwd, w_stop, w_starve, w_starve_rise;

    assign w_op          = i_fifo_data[7:0];
    assign w_pop         = (r_state == RUN) && i_enable && !i_fifo_empty && (!r_seg_valid || i_seg_ready);
    assign w_fwd         = w_pop && (w_op != 8'h00) && (w_op != 8'hFF);
    assign w_stop        = w_pop && (w_op == 8'hFF);
    assign w_starve      = (r_state == RUN) && r_primed && !r_seg_valid && i_fifo_empty;
    assign w_starve_rise = w_starve && !r_starve_d;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_enable ? RUN : IDLE;
            RUN:     w_next = w_stop ? HALTED : (i_enable ? RUN : IDLE);
            HALTED:  w_next = i_clear ? IDLE : HALTED;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= IDLE;
            r_seg_valid      <= 1'b0;
            r_seg_data       <= '0;
            r_halted         <= 1'b0;
            r_underrun       <= 1'b0;
            r_primed         <= 1'b0;
            r_starve_d       <= 1'b0;
            r_records_out    <= '0;
            r_underrun_count <= '0;
        end else begin
            r_state    <= w_next;
            r_primed   <= (r_state == RUN) && (r_primed || w_fwd);
            r_starve_d <= w_starve;
            if (w_fwd) begin
                r_seg_data  <= i_fifo_data;
                r_seg_valid <= 1'b1;
            end else if (i_seg_ready) begin
                r_seg_valid <= 1'b0;
            end
            // STOP beats a coincident clear; counters still zero underneath it
            r_halted         <= w_stop || (r_halted && !i_clear);
            r_underrun       <= !i_clear && (r_underrun || w_starve_rise);
            r_records_out    <= (i_clear ? '0 : r_records_out) + {{(CountWidth-1){1'b0}}, w_fwd};
            r_underrun_count <= i_clear ? '0 : r_underrun_count + {{(CountWidth-1){1'b0}}, w_starve_rise};
        end
    end

    assign o_fifo_read_en   = w_pop;
    assign o_seg_valid      = r_seg_valid;
    assign o_seg_data       = r_seg_data;
    assign o_halted         = r_halted;
    assign o_underrun       = r_underrun;
    assign o_records_out    = r_records_out;
    assign o_underrun_count = r_underrun_count;
endmodule

// File: doc/record_sequencer.md
# record_sequencer

Pops complete records from the byte-to-record `fifo` and presents them to the motion engine over a valid/ready interface. Record byte 0 is an opcode: `0x00` records (NOP) are dropped, `0xFF` records (STOP) halt the sequencer, and all other records are forwarded. Sits between the host-facing fifo and the step generator. Owns the fifo `read_en` and reports underrun and throughput status to the host register block.

## Interface
- `WordSize`, 8: fifo word width in bits.
- `RecordWords`, 16: words per record. Record width `RecW = WordSize*RecordWords`.
- `CountWidth`, 16: width of the status counters.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `enable`  in  1  level. Sequencer runs while high.
- `clear`  in  1  one-cycle pulse. Clears halt, underrun flag and counters.
- `fifo_empty`  in  1  fifo `empty`: no complete record available.
- `fifo_data`  in  RecW  fifo `data_out`: head record, word 0 in bits [WordSize-1:0].
- `fifo_read_en`  out  1  combinational pop strobe to fifo `read_en`.
- `seg_valid`  out  1  registered. `seg_data` holds a record.
- `seg_ready`  in  1  downstream accepts when `seg_valid && seg_ready`.
- `seg_data`  out  RecW  registered forwarded record.
- `halted`  out  1  a STOP record was consumed.
- `underrun`  out  1  sticky starvation flag.
- `records_out`  out  CountWidth  forwarded-record count, wraps.
- `underrun_count`  out  CountWidth  starvation events, wraps.

## Operation
- The opcode is `fifo_data[7:0]`.
- States are IDLE, RUN and HALTED.
  - IDLE -> RUN when `enable`=1.
  - RUN -> IDLE when `enable`=0.
  - RUN -> HALTED on popping a STOP record.
  - HALTED -> IDLE on `clear`. `enable` is ignored in HALTED.
- Pop condition `pop = (state==RUN) && enable && !fifo_empty && (!seg_valid || seg_ready)`. `fifo_read_en = pop`. There are never pops outside RUN.
- On `pop`, by opcode:
  - 0x00: record discarded, no output change except `seg_valid` clearing if it was accepted.
  - 0xFF: record discarded, `halted`<=1, state<=HALTED.
  - Any other opcode: `seg_data`<=`fifo_data`, `seg_valid`<=1, `records_out`+=1.
- Without a forwarding pop, `seg_valid` clears when `seg_valid && seg_ready`.
- `seg_data` and `seg_valid` are held unchanged until accepted, in every state. Leaving RUN or halting never drops or alters a pending record.
- `primed` (internal) is set on a forwarded pop in RUN and cleared whenever the state is not RUN.
- Starvation condition `starve = (state==RUN) && primed && !seg_valid && fifo_empty`.
  - On the rising edge of `starve`: `underrun`<=1 and `underrun_count`+=1.
  - A continuous starve period counts once.
- `clear`:
  - Zeroes `underrun`, `records_out`, `underrun_count` and `halted`.
  - HALTED -> IDLE. In other states the state is unchanged.
  - If a STOP pop and `clear` coincide, the STOP wins: `halted`=1, state HALTED, counters zeroed.
  - If a forwarding pop and `clear` coincide, `records_out` becomes 1.
- Counters are unsigned and wrap modulo 2^CountWidth.

## Timing
- Reset values: state IDLE, `seg_valid`=0, `seg_data`=0, `halted`=0, `underrun`=0, both counters 0, `primed`=0. `fifo_read_en`=0 because the state is IDLE.
- Asserting `rst_n` low mid-transfer clears everything immediately, including a pending `seg_valid`.
- `enable` rising at edge N: state is RUN after edge N. The earliest `fifo_read_en` is in the cycle following edge N.
- Pop in cycle k: the fifo advances at edge k. The record is on `seg_data` with `seg_valid`=1 from cycle k+1.
- Throughput is one record per cycle while `seg_ready`=1 and the fifo is non-empty. Pop and accept in the same cycle are legal.
- `enable` falling: `fifo_read_en` drops combinationally in the same cycle. The state is IDLE after the next edge.
- `fifo_read_en` is never high while `fifo_empty`=1.

## Test plan
- Reset, then `enable`=1, `seg_ready`=1, fill the fifo with 3 records of opcodes 0x01, 0x02, 0x03 -> `fifo_read_en` high for 3 consecutive cycles, `seg_data[7:0]` shows 01, 02, 03 on consecutive cycles, `records_out`=3, `underrun`=1 after the fifo empties.
- Hold `seg_ready`=0 with 2 records queued -> one pop, `seg_valid` stays 1 with constant data, no further `fifo_read_en`. Release `seg_ready` -> second record appears the next cycle.
- Records 0x00, 0x05, 0xFF, 0x06 -> only 0x05 forwarded, `halted`=1, the 0x06 record stays in the fifo. `clear` pulse -> IDLE, `halted`=0, `records_out`=0, then 0x06 forwarded once `enable` is seen.
- Drop `enable` while a record is pending and `seg_ready`=0 -> no pops, `seg_data` held, accepted when `seg_ready` rises, state IDLE.
- Starve twice (fifo empty for 5 cycles, refill, empty again) -> `underrun_count`=2, not 10. Assert `rst_n` low mid-stream -> all outputs at reset values immediately.
